ifu_iccm_dma_arb: RTL
=====================

Name: ifu_iccm_dma_arb

Overview:
- Arbitrates the single ICCM port between the fetch pipe and DMA ICCM accesses.
- Normally grants DMA only in cycles where fetch reports it is not using the ICCM (ifc_dma_access_ok).
- If DMA waits too long, drives dma_iccm_stall_any to force a fetch-pipe stall.
- Bounds each forced DMA burst, then guarantees fetch a cool-down window. Sits between the DMA slave and the IFU fetch control.

Parameters:
- MAX_WAIT, 8: ungranted pending-request cycles before forcing a fetch stall (legal 1..2**CNT_W-1).
- BURST_MAX, 4: maximum DMA grants per forced-stall episode (legal 1..2**CNT_W-1).
- FETCH_MIN, 2: cycles the forced stall stays deasserted after an episode (legal 1..2**CNT_W-1).
- CNT_W, 4: width of the internal counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active high
- dma_iccm_req  in  1  DMA has a single-beat ICCM access pending; held until granted
- iccm_busy  in  1  ICCM array busy (multi-cycle write or ECC correction); no grant
- ifc_dma_access_ok  in  1  fetch is not using the ICCM this cycle
- dec_tlu_dbg_halted  in  1  core halted in debug
- iccm_dma_gnt  out  1  DMA access granted this cycle (combinational)
- dma_iccm_stall_any  out  1  force fetch stall (registered)
- dma_wait_cycles  out  16  perf: saturating DMA wait count (see Optional Feature)
- dma_force_events  out  8  perf: saturating forced-episode count (see Optional Feature)

Behaviour:
- Everything updates on the rising edge of clk.
- Reset state: state=IDLE, wait_cnt=0, burst_cnt=0, cool_cnt=0, dma_iccm_stall_any=0. While rst=1, iccm_dma_gnt is forced to 0.
- rst has priority over every other input in the same cycle, including a mid-burst reset.
- Grant eligibility: elig = dma_iccm_req & ~iccm_busy & (ifc_dma_access_ok | dec_tlu_dbg_halted).
- iccm_dma_gnt = elig & ~rst, in all states. At most one grant per cycle.
- States (2-bit): IDLE=00, WAIT=01, FORCE=10, COOL=11.
- IDLE:
  - req & ~gnt → WAIT, wait_cnt=1.
  - Otherwise stay in IDLE.
- WAIT:
  - gnt → IDLE, wait_cnt=0.
  - ~req → IDLE, wait_cnt=0.
  - req & ~gnt & wait_cnt==MAX_WAIT-1 & ~dec_tlu_dbg_halted → FORCE; dma_iccm_stall_any=1 next cycle; burst_cnt=0.
  - Otherwise wait_cnt+1.
  - When halted, wait_cnt holds and FORCE is never entered.
- FORCE:
  - dma_iccm_stall_any stays 1.
  - Each gnt increments burst_cnt.
  - Exit to COOL when (gnt & burst_cnt==BURST_MAX-1), or ~req, or dec_tlu_dbg_halted.
  - On exit: dma_iccm_stall_any=0 next cycle, cool_cnt=FETCH_MIN, wait_cnt=0.
  - Fetch sees the stall one cycle late through its own flop, so the first grant in FORCE arrives no earlier than 2 cycles after entry.
- COOL:
  - dma_iccm_stall_any=0.
  - cool_cnt decrements each cycle; the wait timer is frozen.
  - Grants still allowed opportunistically (elig unchanged).
  - At cool_cnt==1 → WAIT if req & ~gnt (wait_cnt=1), else IDLE.
- Simultaneous events:
  - Grant in the same cycle WAIT times out: the grant wins; go to IDLE, not FORCE.
  - iccm_busy during FORCE: no grant, burst_cnt holds, stall remains asserted.
- Counter arithmetic is unsigned CNT_W-bit; counters never wrap, because the state transitions bound them.
- MAX_WAIT=1: FORCE is entered after one ungranted cycle in WAIT.

Optional Feature:
- Macro: RV_ICCM_DMA_ARB_PERF_EN.
- Defined:
  - dma_wait_cycles increments every cycle dma_iccm_req & ~iccm_dma_gnt, saturating at 16'hFFFF.
  - dma_force_events increments on each WAIT→FORCE transition, saturating at 8'hFF.
  - Both clear on rst.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset: rst=1 for 3 cycles with dma_iccm_req=1, ok=1 → gnt=0 and stall=0 throughout; first cycle after rst deasserts → gnt=1.
- Opportunistic grant: ok=1, busy=0, req pulsed 1 cycle → gnt=1 same cycle, state stays IDLE, stall never 1.
- Starvation: MAX_WAIT=8, ok=0, req held → stall=1 on cycle 9 after req. Then ok rises 2 cycles later and busy=0 → gnt each cycle for 4 cycles (BURST_MAX=4), stall=0 the cycle after the 4th grant, then 2 cool cycles.
- Timeout/grant collision: ok goes 1 exactly on wait_cnt==7 → gnt=1, state→IDLE, stall stays 0, dma_force_events unchanged.
- Busy in FORCE: after FORCE entry, ok=1 and busy=1 for 3 cycles → no gnt, burst_cnt=0, stall=1; busy→0 → grants resume and the count reaches 4.
- Halt/perf: dec_tlu_dbg_halted=1, ok=0, req held 20 cycles → gnt=1 immediately, never FORCE. With RV_ICCM_DMA_ARB_PERF_EN: 10 ungranted req cycles → dma_wait_cycles=10; 300 forced episodes → dma_force_events=255.

Source files
------------

// File: rtl/ifu_iccm_dma_arb.sv
// ---------------------------------------------------------------------------
// ifu_iccm_dma_arb
//
// Shares the single ICCM port between the fetch pipe and DMA ICCM accesses.
// DMA normally gets the port only in cycles where fetch says it does not
// need it. If a DMA request goes ungranted for too long, the arbiter forces
// a fetch stall. It allows a bounded number of DMA grants during that stall
// and then holds the stall off for a cool-down window so fetch can progress.
//
// Handshake: dma_iccm_req is held high until the cycle in which
// iccm_dma_gnt is high. That cycle completes one single-beat access.
// iccm_dma_gnt is combinational from the current inputs and never depends
// on the forced-stall state.
//
// Ports:
//   clk                 core clock
//   rst                 synchronous reset, active high
//   dma_iccm_req        DMA single-beat access pending
//   iccm_busy           ICCM array busy, no grant possible
//   ifc_dma_access_ok   fetch is not using the ICCM this cycle
//   dec_tlu_dbg_halted  core halted in debug (DMA may always use the port)
//   iccm_dma_gnt        DMA granted this cycle (combinational)
//   dma_iccm_stall_any  force fetch stall (registered)
//   dma_wait_cycles     perf: saturating count of ungranted request cycles
//   dma_force_events    perf: saturating count of forced-stall episodes
//
// Optional feature macro: RV_ICCM_DMA_ARB_PERF_EN enables the two perf
// counters. When the macro is undefined, both perf outputs are tied to zero.
// ---------------------------------------------------------------------------
module ifu_iccm_dma_arb #(
  parameter int MAX_WAIT  = 8,
  parameter int BURST_MAX = 4,
  parameter int FETCH_MIN = 2,
  parameter int CNT_W     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_iccm_req,
  input  logic        iccm_busy,
  input  logic        ifc_dma_access_ok,
  input  logic        dec_tlu_dbg_halted,
  output logic        iccm_dma_gnt,
  output logic        dma_iccm_stall_any,
  output logic [15:0] dma_wait_cycles,
  output logic [7:0]  dma_force_events
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] WAIT  = 2'b01;
  localparam logic [1:0] FORCE = 2'b10;
  localparam logic [1:0] COOL  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);
  localparam logic [CNT_W-1:0] COOL_INIT  = CNT_W'(FETCH_MIN);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] cool_cnt_q, cool_cnt_d;
  logic             stall_q, stall_d;
  logic             elig;

  assign elig = dma_iccm_req & ~iccm_busy & (ifc_dma_access_ok | dec_tlu_dbg_halted);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
      cool_cnt_q  <= '0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      cool_cnt_q  <= cool_cnt_d;
      stall_q     <= stall_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;
    cool_cnt_d  = cool_cnt_q;
    case (state_q)
      IDLE: begin
        if (dma_iccm_req & ~iccm_dma_gnt) begin
          state_d    = WAIT;
          wait_cnt_d = CNT_ONE;
        end
      end
      WAIT: begin
        // A grant beats a timeout in the same cycle.
        if (iccm_dma_gnt | ~dma_iccm_req) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (dec_tlu_dbg_halted) begin
          wait_cnt_d = wait_cnt_q;
        end else if (wait_cnt_q >= WAIT_LAST) begin
          // '>=' lets MAX_WAIT=1 time out after a single WAIT cycle.
          state_d     = FORCE;
          burst_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
      end
      FORCE: begin
        if (iccm_dma_gnt) begin
          burst_cnt_d = burst_cnt_q + CNT_ONE;
        end
        if ((iccm_dma_gnt & (burst_cnt_q == BURST_LAST)) | ~dma_iccm_req | dec_tlu_dbg_halted) begin
          state_d     = COOL;
          cool_cnt_d  = COOL_INIT;
          wait_cnt_d  = '0;
          burst_cnt_d = '0;
        end
      end
      default: begin // COOL: the wait timer is frozen until the window ends
        if (cool_cnt_q == CNT_ONE) begin
          cool_cnt_d = '0;
          if (dma_iccm_req & ~iccm_dma_gnt) begin
            state_d    = WAIT;
            wait_cnt_d = CNT_ONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cool_cnt_d = cool_cnt_q - CNT_ONE;
        end
      end
    endcase
  end

  // Output logic. The stall is high exactly while the FSM sits in FORCE.
  always_comb begin
    iccm_dma_gnt = elig & ~rst;
    stall_d      = (state_d == FORCE);
  end

  assign dma_iccm_stall_any = stall_q;

`ifdef RV_ICCM_DMA_ARB_PERF_EN
  logic [15:0] wait_cycles_q, wait_cycles_d;
  logic [7:0]  force_events_q, force_events_d;

  always_comb begin
    wait_cycles_d  = wait_cycles_q;
    force_events_d = force_events_q;
    if (dma_iccm_req & ~iccm_dma_gnt & (wait_cycles_q != 16'hFFFF)) begin
      wait_cycles_d = wait_cycles_q + 16'd1;
    end
    if ((state_q == WAIT) & (state_d == FORCE) & (force_events_q != 8'hFF)) begin
      force_events_d = force_events_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cycles_q  <= '0;
      force_events_q <= '0;
    end else begin
      wait_cycles_q  <= wait_cycles_d;
      force_events_q <= force_events_d;
    end
  end

  assign dma_wait_cycles  = wait_cycles_q;
  assign dma_force_events = force_events_q;
`else
  assign dma_wait_cycles  = 16'd0;
  assign dma_force_events = 8'd0;
`endif

endmodule
